spu_adsr_envelope: RTL
======================

// Module: spu_adsr_envelope
// PURPOSE
//  Single-voice SPU ADSR envelope stepper. On each sample tick it reads the
//  step size for the current phase from the rate ROM pair (integer part and
//  21-bit fractional part, RateTableAdd_f), then advances a 15.21 fixed-point
//  envelope. The envelope level goes to the voice volume multiplier.
// PARAMETERS
//  ROM_LAT  1   cycles from rom_read to valid rom_add/rom_add_f (ROMs are registered)
//  INT_W    15  width of integer ROM output rom_add
// PORTS
//  m_clock    in   1      clock
//  p_reset    in   1      asynchronous reset, active-high
//  key_on     in   1      1-cycle pulse: restart envelope in ATTACK
//  key_off    in   1      1-cycle pulse: enter RELEASE
//  tick       in   1      1-cycle sample strobe (44.1 kHz)
//  adsr1      in   16     [15] attack exp, [14:8] attack rate, [7:4] decay rate, [3:0] sustain level
//  adsr2      in   16     [15] sustain exp, [14] sustain dec(1)/inc(0), [12:6] sustain rate, [5] release exp, [4:0] release rate
//  rom_adrs   out  7      rate index to both rate ROMs
//  rom_read   out  1      ROM read strobe
//  rom_add    in   INT_W  integer step
//  rom_add_f  in   21     fractional step
//  env_level  out  15     envelope level 0..0x7FFF
//  env_valid  out  1      1-cycle pulse when env_level updated
//  phase      out  3      0 OFF, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//  busy       out  1      sequencer not in IDLE
//  overrun    out  1      sticky: tick arrived while busy; cleared by key_on
// BEHAVIOUR
//  Reset: all outputs 0; accumulator acc[35:0] = 0; phase OFF; sequencer IDLE.
//  Rate index: ATTACK adsr1[14:8]; DECAY {1'b0,adsr1[7:4],2'b00}; SUSTAIN adsr2[12:6];
//   RELEASE {adsr2[4:0],2'b00}. adsr1/adsr2 are sampled in ISSUE.
//  Sequencer: IDLE -tick & phase!=OFF-> ISSUE (rom_read=1, rom_adrs=idx, 1 cycle)
//   -> WAIT (ROM_LAT cycles) -> CALC (latch step, update acc/phase) -> IDLE.
//   env_valid pulses the cycle after CALC. Latency from tick to env_valid = ROM_LAT+3.
//  Tick with phase OFF: ignored, no ROM read. Tick while busy: dropped, overrun=1.
//  step = {rom_add, rom_add_f} (INT_W+21 bits). acc = {level[14:0], frac[20:0]}.
//  Increase (ATTACK; SUSTAIN with dec=0): linear acc+=step. Exp mode: if level>=0x6000,
//   acc+=step>>2. Saturate at {15'h7FFF,21'h1FFFFF} when the result is >= 2^36.
//  Decrease (DECAY, RELEASE, SUSTAIN dec=1): DECAY is always exponential; the others
//   use their exp bit. Exp: acc-=(step*level)>>15 (full-width product, truncate).
//   Linear: acc-=step. Clamp at 0.
//  Transitions (in CALC, after update): ATTACK->DECAY when level==0x7FFF;
//   DECAY->SUSTAIN when level<=SL, SL=min((adsr1[3:0]+1)<<11,0x7FFF); acc is then
//   set to {SL,21'h0}. SUSTAIN holds until key_off. RELEASE->OFF when acc==0.
//  key_on (any state/cycle): acc=0, phase ATTACK, sequencer aborts to IDLE,
//   overrun=0, no env_valid for an aborted step. key_on beats key_off in the same cycle.
//  key_off: phase RELEASE from ATTACK/DECAY/SUSTAIN with level kept; in OFF, ignored.
//   When it arrives mid-step, the in-flight CALC still completes with the old phase's step.
//  tick and key_on in the same cycle: key_on applied; tick dropped, no overrun.
//  p_reset mid-step: immediate return to reset state; rom_read deasserts.
// TESTING
//  1 Reset, then tick x3 with phase OFF -> rom_read never asserted; env_level=0; env_valid=0.
//  2 key_on; adsr1=0x7F00 (linear, rate 0x7F); ROM stub gives add=0, add_f=8 -> after
//    2^18 ticks acc=2^21, env_level=1; rom_adrs=0x7F; env_valid 4 cycles after each tick.
//  3 ATTACK with add=0x4000 -> level 0x4000, 0x7FFF (saturated), phase=2 on the second step.
//  4 DECAY with adsr1[3:0]=7 (SL=0x4000), large step -> level clamps to exactly 0x4000,
//    phase=3; rom_adrs={adsr1[7:4],2'b00}.
//  5 key_off in SUSTAIN; linear release, step=0x1000<<21, level 0x4000 -> 4 ticks to 0,
//    then phase=0; the next tick gives no rom_read.
//  6 tick while busy -> overrun=1, no extra step; key_on in WAIT -> no env_valid,
//    overrun=0, phase=1, env_level=0.

Source files
------------

// File: rtl/spu_adsr_envelope.sv
// Single-voice ADSR envelope stepper: one ROM-driven step per sample tick,
// applied to a 15.21 fixed-point accumulator whose integer part is the level.
module spu_adsr_envelope #(
  parameter int ROM_LAT = 1,
  parameter int INT_W   = 15
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             key_on,
  input  logic             key_off,
  input  logic             tick,
  input  logic [15:0]      adsr1,
  input  logic [15:0]      adsr2,
  output logic [6:0]       rom_adrs,
  output logic             rom_read,
  input  logic [INT_W-1:0] rom_add,
  input  logic [20:0]      rom_add_f,
  output logic [14:0]      env_level,
  output logic             env_valid,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             overrun
);

  localparam int STEP_W = INT_W + 21;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_CALC  = 2'd3
  } seq_e;

  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_e;

  seq_e              seq_q, seq_d;
  phase_e            ph_q, op_ph_q, ph_calc;
  logic [35:0]       acc_q, acc_upd, acc_calc;
  logic [STEP_W-1:0] step_q;
  logic [7:0]        wait_q;
  logic              atk_exp_q, sus_exp_q, sus_dec_q, rel_exp_q;
  logic [3:0]        sl_code_q;
  logic              env_valid_q, overrun_q;
  logic [6:0]        idx;

  // Rate index for the phase the voice is in right now.
  always_comb begin
    idx = 7'd0;
    case (ph_q)
      PH_ATTACK:  idx = adsr1[14:8];
      PH_DECAY:   idx = {1'b0, adsr1[7:4], 2'b00};
      PH_SUSTAIN: idx = adsr2[12:6];
      PH_RELEASE: idx = {adsr2[4:0], 2'b00};
      default:    idx = 7'd0;
    endcase
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) seq_q <= SEQ_IDLE;
    else         seq_q <= seq_d;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    seq_d    = seq_q;
    rom_read = (seq_q == SEQ_ISSUE);
    rom_adrs = (seq_q == SEQ_ISSUE) ? idx : 7'd0;
    busy     = (seq_q != SEQ_IDLE);
    if (key_on) begin
      seq_d = SEQ_IDLE;
    end else begin
      case (seq_q)
        SEQ_IDLE:  if (tick && ph_q != PH_OFF) seq_d = SEQ_ISSUE;
        SEQ_ISSUE: seq_d = SEQ_WAIT;
        SEQ_WAIT:  if (wait_q == 8'd0) seq_d = SEQ_CALC;
        SEQ_CALC:  seq_d = SEQ_IDLE;
        default:   seq_d = SEQ_IDLE;
      endcase
    end
  end

  // Step arithmetic; direction and exp mode come from the phase captured at issue.
  logic [14:0] level, sl;
  logic [15:0] sl_raw;
  logic [35:0] step, inc_step, dec_amt, dec_sel;
  logic [36:0] sum;
  logic [50:0] prod;
  logic        is_inc, use_exp;

  always_comb begin
    level    = acc_q[35:21];
    step     = 36'(step_q);
    sl_raw   = 16'({1'b0, sl_code_q} + 5'd1) << 11;
    sl       = sl_raw[15] ? 15'h7FFF : sl_raw[14:0];
    is_inc   = (op_ph_q == PH_ATTACK) || (op_ph_q == PH_SUSTAIN && !sus_dec_q);
    use_exp  = 1'b0;
    case (op_ph_q)
      PH_ATTACK:  use_exp = atk_exp_q;
      PH_DECAY:   use_exp = 1'b1;
      PH_SUSTAIN: use_exp = sus_exp_q;
      PH_RELEASE: use_exp = rel_exp_q;
      default:    use_exp = 1'b0;
    endcase
    inc_step = (use_exp && level >= 15'h6000) ? (step >> 2) : step;
    sum      = {1'b0, acc_q} + {1'b0, inc_step};
    prod     = 51'(step) * 51'(level);
    dec_amt  = 36'(prod >> 15);
    dec_sel  = use_exp ? dec_amt : step;
    if (is_inc) acc_upd = sum[36] ? '1 : sum[35:0];
    else        acc_upd = (dec_sel > acc_q) ? '0 : acc_q - dec_sel;

    acc_calc = acc_upd;
    ph_calc  = op_ph_q;
    case (op_ph_q)
      PH_ATTACK:  if (acc_upd[35:21] == 15'h7FFF) ph_calc = PH_DECAY;
      PH_DECAY: begin
        if (acc_upd[35:21] <= sl) begin
          ph_calc  = PH_SUSTAIN;
          acc_calc = {sl, 21'h0};
        end
      end
      PH_RELEASE: if (acc_upd == '0) ph_calc = PH_OFF;
      default:    ph_calc = op_ph_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so the later
  // key_off assignment cleanly overrides a CALC transition in the same cycle.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      acc_q       <= '0;
      ph_q        <= PH_OFF;
      op_ph_q     <= PH_OFF;
      step_q      <= '0;
      wait_q      <= 8'd0;
      atk_exp_q   <= 1'b0;
      sus_exp_q   <= 1'b0;
      sus_dec_q   <= 1'b0;
      rel_exp_q   <= 1'b0;
      sl_code_q   <= 4'd0;
      env_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      env_valid_q <= 1'b0;
      if (key_on) begin
        acc_q     <= '0;
        ph_q      <= PH_ATTACK;
        overrun_q <= 1'b0;
      end else begin
        if (tick && seq_q != SEQ_IDLE) overrun_q <= 1'b1;
        case (seq_q)
          SEQ_ISSUE: begin
            op_ph_q   <= ph_q;
            atk_exp_q <= adsr1[15];
            sl_code_q <= adsr1[3:0];
            sus_exp_q <= adsr2[15];
            sus_dec_q <= adsr2[14];
            rel_exp_q <= adsr2[5];
            wait_q    <= 8'(ROM_LAT - 1);
          end
          SEQ_WAIT: begin
            if (wait_q == 8'd0) step_q <= {rom_add, rom_add_f};
            else                wait_q <= wait_q - 8'd1;
          end
          SEQ_CALC: begin
            env_valid_q <= 1'b1;
            // A key_off during the step already moved the phase; keep it.
            if (ph_q == op_ph_q) begin
              acc_q <= acc_calc;
              ph_q  <= ph_calc;
            end else begin
              acc_q <= acc_upd;
            end
          end
          default: ;
        endcase
        if (key_off && (ph_q == PH_ATTACK || ph_q == PH_DECAY || ph_q == PH_SUSTAIN))
          ph_q <= PH_RELEASE;
      end
    end
  end

  assign env_level = acc_q[35:21];
  assign env_valid = env_valid_q;
  assign phase     = ph_q;
  assign overrun   = overrun_q;

endmodule
